// File: rtl/cpu_hatch_arbiter.sv
// Two-requester arbiter for the shared instruction-memory (hatch) read port.
// Round-robin with bounded bursts; a fixed-latency pipe routes each return to its issuer.
module cpu_hatch_arbiter #(
  parameter int LATENCY = 1,
  parameter int BURST   = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        req_0,
  input  logic [31:0] addr_0,
  output logic        gnt_0,
  output logic        rvalid_0,
  output logic [47:0] rdata_0,
  input  logic        req_1,
  input  logic [31:0] addr_1,
  output logic        gnt_1,
  output logic        rvalid_1,
  output logic [47:0] rdata_1,
  output logic        hatch_en,
  output logic [31:0] hatch_address,
  input  logic [47:0] hatch_instruction
);

  // Handshake: a requester holds req_N with addr_N stable until gnt_N is high in the
  // same cycle (the grant cycle); the read returns exactly LATENCY cycles later on
  // rvalid_N/rdata_N. There is no back-pressure on the return path.

  localparam logic [3:0] BURST_C = 4'(BURST);

  logic                last, last_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic                grant, win;
  logic                req_last, req_other;
  logic [LATENCY-1:0]  pipe_v, pipe_id;
  logic [31:0]         addr_q;
  logic [47:0]         rdata_0_q, rdata_1_q;

  assign req_last  = last ? req_1 : req_0;
  assign req_other = last ? req_0 : req_1;

  // State register: arbitration state, return pipe and held output copies.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      last      <= 1'b1;
      cnt       <= 4'd0;
      pipe_v    <= '0;
      pipe_id   <= '0;
      addr_q    <= 32'd0;
      rdata_0_q <= 48'd0;
      rdata_1_q <= 48'd0;
    end else begin
      last       <= last_nxt;
      cnt        <= cnt_nxt;
      pipe_v[0]  <= grant;
      pipe_id[0] <= win;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_v[i]  <= pipe_v[i-1];
        pipe_id[i] <= pipe_id[i-1];
      end
      if (grant)    addr_q    <= hatch_address;
      if (rvalid_0) rdata_0_q <= hatch_instruction;
      if (rvalid_1) rdata_1_q <= hatch_instruction;
    end
  end

  // Next-state logic. cnt == 0 means no burst is in progress (after reset or an idle
  // cycle), so the side that did not win last gets first pick.
  always_comb begin
    grant    = 1'b0;
    win      = last;
    last_nxt = last;
    cnt_nxt  = cnt;
    if (req_last && (cnt != 4'd0) && (cnt < BURST_C)) begin
      grant   = 1'b1;
      cnt_nxt = cnt + 4'd1;
    end else if (req_other) begin
      grant    = 1'b1;
      win      = ~last;
      last_nxt = ~last;
      cnt_nxt  = 4'd1;
    end else if (req_last) begin
      grant = 1'b1;
      if (cnt < BURST_C) cnt_nxt = cnt + 4'd1;
    end else begin
      cnt_nxt = 4'd0;
    end
    if (!rst_b) grant = 1'b0;
  end

  // Outputs: grants and memory strobe, plus pass-through of returning data.
  always_comb begin
    gnt_0         = grant & ~win;
    gnt_1         = grant & win;
    hatch_en      = grant;
    hatch_address = grant ? (win ? addr_1 : addr_0) : addr_q;
    rvalid_0      = rst_b & pipe_v[LATENCY-1] & ~pipe_id[LATENCY-1];
    rvalid_1      = rst_b & pipe_v[LATENCY-1] & pipe_id[LATENCY-1];
    rdata_0       = rvalid_0 ? hatch_instruction : rdata_0_q;
    rdata_1       = rvalid_1 ? hatch_instruction : rdata_1_q;
  end

endmodule

// File: tb/tb_cpu_hatch_arbiter.sv
// Directed bench for cpu_hatch_arbiter: LATENCY=1 and LATENCY=3 instances share stimulus,
// each fed by a simple memory model that returns {16'hAAAA, address}.
module tb_cpu_hatch_arbiter;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b, req_0, req_1;
  logic [31:0] addr_0, addr_1;

  logic        g0_1, g1_1, rv0_1, rv1_1, he_1;
  logic [47:0] rd0_1, rd1_1, hi_1;
  logic [31:0] ha_1;
  logic        g0_3, g1_3, rv0_3, rv1_3, he_3;
  logic [47:0] rd0_3, rd1_3, hi_3;
  logic [31:0] ha_3;

  cpu_hatch_arbiter #(.LATENCY(1), .BURST(4)) u_l1 (
    .clk(clk), .rst_b(rst_b),
    .req_0(req_0), .addr_0(addr_0), .gnt_0(g0_1), .rvalid_0(rv0_1), .rdata_0(rd0_1),
    .req_1(req_1), .addr_1(addr_1), .gnt_1(g1_1), .rvalid_1(rv1_1), .rdata_1(rd1_1),
    .hatch_en(he_1), .hatch_address(ha_1), .hatch_instruction(hi_1)
  );

  cpu_hatch_arbiter #(.LATENCY(3), .BURST(4)) u_l3 (
    .clk(clk), .rst_b(rst_b),
    .req_0(req_0), .addr_0(addr_0), .gnt_0(g0_3), .rvalid_0(rv0_3), .rdata_0(rd0_3),
    .req_1(req_1), .addr_1(addr_1), .gnt_1(g1_3), .rvalid_1(rv1_3), .rdata_1(rd1_3),
    .hatch_en(he_3), .hatch_address(ha_3), .hatch_instruction(hi_3)
  );

  // Memory models: data for an address appears LATENCY cycles after it is presented.
  logic [31:0] m1, m3_a, m3_b, m3_c;
  always @(posedge clk) begin
    m1   <= ha_1;
    m3_a <= ha_3;
    m3_b <= m3_a;
    m3_c <= m3_b;
  end
  assign hi_1 = {16'hAAAA, m1};
  assign hi_3 = {16'hAAAA, m3_c};

  // Scoreboard state
  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  logic        g_v  [256];
  logic        g_id [256];
  logic        rs   [256];
  logic [31:0] g_a  [256];
  logic [47:0] ld   [2][2];
  logic [31:0] last_a;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Return check for one instance: a grant at cycle g returns at g+L unless a reset
  // cycle occurred anywhere in g..g+L.
  task automatic ret_chk(input int lat, input logic rv0, input logic rv1,
                         input logic [47:0] rd0, input logic [47:0] rd1);
    int   g;
    int   k;
    logic ev;
    logic eid;
    g   = cyc - lat;
    k   = (lat == 3) ? 1 : 0;
    ev  = 1'b0;
    eid = 1'b0;
    if (g >= 0 && g_v[g] === 1'b1) begin
      ev = 1'b1;
      for (int j = g; j <= cyc; j++) if (rs[j]) ev = 1'b0;
    end
    if (ev) begin
      eid        = g_id[g];
      ld[k][eid] = {16'hAAAA, g_a[g]};
    end
    chk($sformatf("L%0d rvalid_0", lat), 64'(rv0), 64'(ev & ~eid));
    chk($sformatf("L%0d rvalid_1", lat), 64'(rv1), 64'(ev & eid));
    chk($sformatf("L%0d rdata_0", lat), 64'(rd0), 64'(ld[k][0]));
    chk($sformatf("L%0d rdata_1", lat), 64'(rd1), 64'(ld[k][1]));
  endtask

  // Driver: apply one cycle of stimulus with the hand-computed expected grants.
  task automatic step(input logic rb, input logic r0, input logic r1,
                      input logic [31:0] a0, input logic [31:0] a1,
                      input logic e0, input logic e1);
    rst_b  = rb;
    req_0  = r0;
    req_1  = r1;
    addr_0 = a0;
    addr_1 = a1;
    @(negedge clk);
    chk("L1 gnt_0", 64'(g0_1), 64'(e0));
    chk("L1 gnt_1", 64'(g1_1), 64'(e1));
    chk("L3 gnt_0", 64'(g0_3), 64'(e0));
    chk("L3 gnt_1", 64'(g1_3), 64'(e1));
    chk("L1 hatch_en", 64'(he_1), 64'(e0 | e1));
    chk("L3 hatch_en", 64'(he_3), 64'(e0 | e1));
    if (e0) last_a = a0;
    else if (e1) last_a = a1;
    chk("L1 hatch_address", 64'(ha_1), 64'(last_a));
    chk("L3 hatch_address", 64'(ha_3), 64'(last_a));
    g_v[cyc]  = e0 | e1;
    g_id[cyc] = e1;
    g_a[cyc]  = e1 ? a1 : a0;
    rs[cyc]   = ~rb;
    ret_chk(1, rv0_1, rv1_1, rd0_1, rd1_1);
    ret_chk(3, rv0_3, rv1_3, rd0_3, rd1_3);
    if (!rb) begin
      last_a = 32'd0;
      for (int a = 0; a < 2; a++)
        for (int b = 0; b < 2; b++) ld[a][b] = 48'd0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [11:0] pat;
    logic [4:0]  pat5;
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++) ld[a][b] = 'x;
    last_a = 'x;

    // Reset, with a request present during reset that must not be granted
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h5, 32'h6, 1'b0, 1'b0);

    // Single read from requester 0
    step(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0);
    idle(4);

    // Contention from reset state: 0,0,0,0,1,1,1,1,0,0,0,0
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    pat = 12'b0000_1111_0000;
    for (int i = 0; i < 12; i++)
      step(1'b1, 1'b1, 1'b1, 32'h100 + 32'(i), 32'h200 + 32'(i), ~pat[i], pat[i]);
    idle(4);

    // Solo saturation on requester 1, then requester 0 forces rotation
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b0, 1'b1, 32'h0, 32'h500 + 32'(i), 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 32'h600, 32'h601, 1'b1, 1'b0);
    idle(4);

    // Idle gaps between single pulses
    step(1'b1, 1'b1, 1'b0, 32'h700, 32'h0, 1'b1, 1'b0);
    idle(1);
    step(1'b1, 1'b0, 1'b1, 32'h0, 32'h701, 1'b0, 1'b1);
    idle(1);
    step(1'b1, 1'b1, 1'b0, 32'h702, 32'h0, 1'b1, 1'b0);
    idle(1);
    step(1'b1, 1'b0, 1'b1, 32'h0, 32'h703, 1'b0, 1'b1);
    idle(1);
    // After the idle cycle the burst count is clear, so 0 wins first: 0,0,0,0,1
    pat5 = 5'b10000;
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b1, 1'b1, 32'h800 + 32'(i), 32'h900 + 32'(i), ~pat5[i], pat5[i]);
    idle(4);

    // Five back-to-back reads to requester 0 (pipelined returns on L3)
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b1, 1'b0, 32'h300 + 32'(i), 32'h0, 1'b1, 1'b0);
    idle(4);

    // Reset mid-flight: in-flight reads are discarded, requester 0 wins afterwards
    step(1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h401, 32'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    idle(4);
    step(1'b1, 1'b1, 1'b1, 32'hA00, 32'hB00, 1'b1, 1'b0);
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
